// File: rtl/pipelined_control_unit.sv
// Hazard-aware control unit for the 5-stage 16-bit core: decodes in D, carries the control bundle
// through E/M/W, resolves branches in E and drives stall/flush. Define CU_FORWARDING_EN for forwarding selects.
module pipelined_control_unit #(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 4,
    parameter int REG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic               zero_flag,
    input  logic               ge_flag,
    output logic               reg_write_w,
    output logic [1:0]         result_src_w,
    output logic               mem_write_m,
    output logic [2:0]         alu_ctrl_e,
    output logic               alu_src_e,
    output logic               flags_we_e,
    output logic               pc_src_e,
    output logic [REG_W-1:0]   rd_e,
    output logic [REG_W-1:0]   rd_m,
    output logic [REG_W-1:0]   rd_w,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_d,
    output logic               flush_e,
    output logic               illegal_d
`ifdef CU_FORWARDING_EN
    ,
    output logic [1:0]         forward_a_e,
    output logic [1:0]         forward_b_e
`endif
);

    typedef struct packed {
        logic             reg_write;
        logic [1:0]       result_src;
        logic             mem_write;
        logic [2:0]       alu_ctrl;
        logic             alu_src;
        logic             flags_we;
        logic             jump;
        logic             beq;
        logic             bge;
        logic [REG_W-1:0] rd;
    } ctrl_t;

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd_f;
    logic [REG_W-1:0] rm_f;
    logic [REG_W-1:0] rn_f;
    logic             imm_f;

    assign op    = instr_d[INSTR_W-1 -: OP_W];
    assign rd_f  = instr_d[INSTR_W-OP_W-1 -: REG_W];
    assign rm_f  = instr_d[2*REG_W-1 -: REG_W];
    assign rn_f  = instr_d[REG_W-1:0];
    assign imm_f = instr_d[0];

    // D is invalid for one cycle after a flush zeroed the F/D register
    logic             d_valid_reg;
    ctrl_t            dec;
    logic [1:0]       src_use;
    logic [REG_W-1:0] src_reg [2];

    ctrl_t            e_reg;
    logic             m_reg_write_reg;
    logic [1:0]       m_result_src_reg;
    logic             m_mem_write_reg;
    logic [REG_W-1:0] m_rd_reg;
    logic             w_reg_write_reg;
    logic [1:0]       w_result_src_reg;
    logic [REG_W-1:0] w_rd_reg;

    logic             hazard;
    genvar            gi;

    always_comb begin
        dec        = '0;
        src_use    = '0;
        src_reg[0] = '0;
        src_reg[1] = '0;
        if (d_valid_reg) begin
            dec.rd = rd_f;
            case (op)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                    dec.reg_write = 1'b1;
                    dec.alu_ctrl  = op[2:0];
                    src_use       = 2'b11;
                    src_reg[0]    = rm_f;
                    src_reg[1]    = rn_f;
                end
                4'h5: begin
                    dec.flags_we = 1'b1;
                    dec.alu_ctrl = 3'b001;
                    dec.alu_src  = imm_f;
                    src_use[0]   = ~imm_f;
                    src_reg[0]   = rm_f;
                end
                4'h6: begin
                    dec.reg_write = 1'b1;
                    dec.alu_ctrl  = 3'b101;
                    dec.alu_src   = imm_f;
                    src_use[0]    = ~imm_f;
                    src_reg[0]    = rm_f;
                end
                4'h7: begin
                    dec.reg_write  = 1'b1;
                    dec.result_src = 2'b01;
                    dec.alu_ctrl   = 3'b110;
                    src_use[0]     = 1'b1;
                    src_reg[0]     = rm_f;
                end
                4'h8: begin
                    // a store also reads its data register from the rd field
                    dec.mem_write = 1'b1;
                    dec.alu_ctrl  = 3'b110;
                    src_use       = 2'b11;
                    src_reg[0]    = rm_f;
                    src_reg[1]    = rd_f;
                end
                4'h9:    dec.jump = 1'b1;
                4'hA:    dec.beq  = 1'b1;
                4'hB:    dec.bge  = 1'b1;
                default: ;
            endcase
        end
    end

    assign illegal_d = d_valid_reg && (op >= OP_W'(13));
    assign pc_src_e  = e_reg.jump | (e_reg.beq & zero_flag) | (e_reg.bge & ge_flag);

`ifdef CU_FORWARDING_EN
    logic [1:0]       ld_hit;
    logic [1:0]       use_e_reg;
    logic [REG_W-1:0] src_e_reg [2];
    logic [1:0][1:0]  fwd;

    for (gi = 0; gi < 2; gi++) begin : g_hazard
        assign ld_hit[gi] = src_use[gi] && (src_reg[gi] == e_reg.rd);
        assign fwd[gi] = (use_e_reg[gi] && m_reg_write_reg && (m_rd_reg == src_e_reg[gi])) ? 2'b10 :
                         (use_e_reg[gi] && w_reg_write_reg && (w_rd_reg == src_e_reg[gi])) ? 2'b01 :
                         2'b00;
    end

    assign hazard      = d_valid_reg && (e_reg.result_src == 2'b01) && (|ld_hit);
    assign forward_a_e = fwd[0];
    assign forward_b_e = fwd[1];
`else
    logic [1:0] e_hit;
    logic [1:0] m_hit;

    for (gi = 0; gi < 2; gi++) begin : g_hazard
        assign e_hit[gi] = src_use[gi] && e_reg.reg_write && (src_reg[gi] == e_reg.rd);
        assign m_hit[gi] = src_use[gi] && m_reg_write_reg && (src_reg[gi] == m_rd_reg);
    end

    assign hazard = d_valid_reg && ((|e_hit) || (|m_hit));
`endif

    // a taken branch kills the D instruction, so it wins over any stall
    assign stall_f = hazard & ~pc_src_e;
    assign stall_d = hazard & ~pc_src_e;
    assign flush_d = pc_src_e;
    assign flush_e = pc_src_e | hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_valid_reg      <= 1'b1;
            e_reg            <= '0;
            m_reg_write_reg  <= 1'b0;
            m_result_src_reg <= 2'b00;
            m_mem_write_reg  <= 1'b0;
            m_rd_reg         <= '0;
            w_reg_write_reg  <= 1'b0;
            w_result_src_reg <= 2'b00;
            w_rd_reg         <= '0;
`ifdef CU_FORWARDING_EN
            use_e_reg        <= '0;
            src_e_reg[0]     <= '0;
            src_e_reg[1]     <= '0;
`endif
        end else begin
            if (flush_d)
                d_valid_reg <= 1'b0;
            else if (!stall_d)
                d_valid_reg <= 1'b1;
            e_reg            <= flush_e ? '0 : dec;
            m_reg_write_reg  <= e_reg.reg_write;
            m_result_src_reg <= e_reg.result_src;
            m_mem_write_reg  <= e_reg.mem_write;
            m_rd_reg         <= e_reg.rd;
            w_reg_write_reg  <= m_reg_write_reg;
            w_result_src_reg <= m_result_src_reg;
            w_rd_reg         <= m_rd_reg;
`ifdef CU_FORWARDING_EN
            use_e_reg        <= flush_e ? 2'b00 : src_use;
            src_e_reg[0]     <= src_reg[0];
            src_e_reg[1]     <= src_reg[1];
`endif
        end
    end

    assign alu_ctrl_e   = e_reg.alu_ctrl;
    assign alu_src_e    = e_reg.alu_src;
    assign flags_we_e   = e_reg.flags_we;
    assign rd_e         = e_reg.rd;
    assign mem_write_m  = m_mem_write_reg;
    assign rd_m         = m_rd_reg;
    assign reg_write_w  = w_reg_write_reg;
    assign result_src_w = w_result_src_reg;
    assign rd_w         = w_rd_reg;

endmodule
